kronos_csr_responder: RTL and testbench
=======================================

// Module: kronos_csr_responder
// PURPOSE
//  Machine-mode CSR file; responder end of the pipeline's CSR access interface (CSR_RW/RS/RC).
//  Accepts one request per valid/ready handshake; returns the old CSR value and an error flag.
//  Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mtval; reflects mip.
//  Runs mcycle/minstret counters; drives the interrupt-enable view for trap logic.
// PARAMETERS
//  MTVEC_RESET    32'h0000_0000  mtvec reset value; bits [1:0] forced to DIRECT_MODE
//  COUNTER_WIDTH  64             mcycle/minstret width, legal 33..64; bits above width read 0
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rstz          in   1   asynchronous, active-low reset
//  req_vld       in   1   CSR request valid
//  req_rdy       out  1   responder can accept request
//  req_op        in   2   CSR_RW/CSR_RS/CSR_RC; 2'b00 illegal
//  req_addr      in   12  CSR address (MSTATUS..MINSTRETH)
//  req_wdata     in   32  rs1 value or zimm, zero-extended
//  req_wren      in   1   0 = read-only access (RS/RC with rs1=x0); suppresses write
//  rsp_vld       out  1   response valid
//  rsp_rdy       in   1   response consumed
//  rsp_rdata     out  32  CSR value before the write; 0 on error
//  rsp_err       out  1   illegal access -> pipeline raises ILLEGAL_INSTR
//  instret       in   1   one-cycle pulse per retired instruction
//  irq_sw/irq_timer/irq_ext  in  1 each  level interrupt sources -> mip bits 3/7/11
//  mstatus_mie   out  1   global interrupt enable
//  mie_mask      out  3   {MEIE,MTIE,MSIE}
//  mtvec_base    out  32  trap vector, [1:0]=0
// BEHAVIOUR
//  Reset: req_rdy=1, rsp_vld=0, rsp_rdata=0, rsp_err=0, mstatus MIE=MPIE=0, mie=0,
//   mtvec=MTVEC_RESET&~3, mscratch/mepc/mcause/mtval=0, counters=0.
//  FSM: IDLE (req_rdy=1) -> RESP on req_vld; RESP (req_rdy=0, rsp_vld=1) -> IDLE on rsp_rdy.
//   rsp_rdata/rsp_err stable while RESP and rsp_rdy=0. Latency: response 1 cycle after accept.
//  Access at accept edge: read old value -> rsp_rdata; new = RW:wdata, RS:old|wdata, RC:old&~wdata.
//   Write committed same edge only if req_wren=1 and no error.
//  Errors (no state change, rdata=0): unmapped address; req_op=2'b00; write (req_wren=1) to
//   read-only MIP is NOT an error -- write ignored, old value returned.
//  Field rules: mstatus reads {19'b0,2'b11(MPP),3'b0,MPIE[7],3'b0,MIE[3],3'b0}; only 3,7 writable.
//   mie/mip: bits 3,7,11 only, others read 0. mepc[1:0] read 0. mcause: bit31 + [3:0] only.
//   mtvec[1:0] forced 2'b00. mscratch/mtval full 32 bits.
//  Counters: mcycle +1 every cycle; minstret +1 per instret pulse; wrap all-ones -> 0.
//   MCYCLE/MINSTRET write low 32, ..H write upper bits; a CSR write on the same edge wins
//   over the increment (written value, no +1).
//  Reset asserted mid-transaction: FSM to IDLE, pending response dropped, all state reset.
// CONFIGURATION
//  KRONOS_CSR_COUNTERS_EN defined: mcycle/minstret(+H) implemented as above.
//  Undefined: no counter flops; counter addresses are unmapped -> rsp_err=1, instret ignored.
// TESTING
//  Reset -> RW MTVEC wdata=32'h8000_0103: rsp_rdata=MTVEC_RESET, readback 32'h8000_0100.
//  RS MSTATUS wdata=32'h8 then read: rdata=32'h1808, mstatus_mie=1; RC wdata=8 -> mie clears.
//  RW addr 12'h7C0: rsp_err=1, rdata=0, no state change; req_op=2'b00 also errs.
//  Hold rsp_rdy=0 for 5 cycles: rsp_vld/rdata stable, req_rdy=0, new req_vld not accepted.
//  Counters: RW MCYCLE 32'hFFFF_FFFF -> upper word increments next cycle; 10 instret pulses
//   -> MINSTRET +10; without KRONOS_CSR_COUNTERS_EN, read MCYCLE -> rsp_err=1.
//  irq_timer=1 -> MIP reads 32'h80; RW MIP wdata=0 -> no err, still 32'h80.

Source files
------------

// File: rtl/kronos_csr_responder.sv
// Machine-mode CSR responder: one CSR_RW/RS/RC access per handshake, old value (or error) returned.
// Optional KRONOS_CSR_COUNTERS_EN adds mcycle/minstret(+H); without it those addresses are unmapped.
module kronos_csr_responder #(
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter int unsigned COUNTER_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_wren,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        instret,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic        mstatus_mie,
  output logic [2:0]  mie_mask,
  output logic [31:0] mtvec_base
);
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  // state | meaning
  // IDLE  | req_rdy=1, waiting for a request
  // RESP  | rsp_vld=1, rdata/err held until rsp_rdy
  typedef enum logic {IDLE, RESP} state_e;
  state_e state_q, state_d;

  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [2:0]  mie_q, mie_d;
  logic [31:2] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:2] mepc_q, mepc_d;
  logic        mcause_int_q, mcause_int_d;
  logic [3:0]  mcause_code_q, mcause_code_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mip_val, old_val, new_val;
  logic        hit, err, accept, wr_en;

`ifdef KRONOS_CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  logic [COUNTER_WIDTH-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
  localparam int unsigned UNUSED_COUNTER_WIDTH = COUNTER_WIDTH;
  logic unused_instret;
  assign unused_instret = instret;
`endif

  assign mip_val = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  assign accept  = req_vld && (state_q == IDLE);

  always_comb begin
    old_val = '0;
    hit     = 1'b1;
    case (req_addr)
      ADDR_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
      ADDR_MIE:       old_val = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
      ADDR_MTVEC:     old_val = {mtvec_q, 2'b00};
      ADDR_MSCRATCH:  old_val = mscratch_q;
      ADDR_MEPC:      old_val = {mepc_q, 2'b00};
      ADDR_MCAUSE:    old_val = {mcause_int_q, 27'b0, mcause_code_q};
      ADDR_MTVAL:     old_val = mtval_q;
      ADDR_MIP:       old_val = mip_val;
`ifdef KRONOS_CSR_COUNTERS_EN
      ADDR_MCYCLE:    old_val = mcycle_q[31:0];
      ADDR_MINSTRET:  old_val = minstret_q[31:0];
      ADDR_MCYCLEH:   old_val = 32'(mcycle_q[COUNTER_WIDTH-1:32]);
      ADDR_MINSTRETH: old_val = 32'(minstret_q[COUNTER_WIDTH-1:32]);
`endif
      default:        hit = 1'b0;
    endcase
  end

  always_comb begin
    case (req_op)
      2'b01:   new_val = req_wdata;
      2'b10:   new_val = old_val | req_wdata;
      2'b11:   new_val = old_val & ~req_wdata;
      default: new_val = old_val;
    endcase
  end

  assign err   = !hit || (req_op == 2'b00);
  assign wr_en = accept && req_wren && !err;

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (req_vld) begin
        state_d     = RESP;
        rsp_rdata_d = err ? 32'h0 : old_val;
        rsp_err_d   = err;
      end
      RESP: if (rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MIP is absent here on purpose: writes to it are accepted and dropped.
  always_comb begin
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;
    mtval_d       = mtval_q;
    if (wr_en) begin
      case (req_addr)
        ADDR_MSTATUS: begin
          mst_mie_d  = new_val[3];
          mst_mpie_d = new_val[7];
        end
        ADDR_MIE:      mie_d = {new_val[11], new_val[7], new_val[3]};
        ADDR_MTVEC:    mtvec_d = new_val[31:2];
        ADDR_MSCRATCH: mscratch_d = new_val;
        ADDR_MEPC:     mepc_d = new_val[31:2];
        ADDR_MCAUSE: begin
          mcause_int_d  = new_val[31];
          mcause_code_d = new_val[3:0];
        end
        ADDR_MTVAL:    mtval_d = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q       <= IDLE;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RESET[31:2];
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_int_q  <= 1'b0;
      mcause_code_q <= '0;
      mtval_q       <= '0;
    end else begin
      state_q       <= state_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_int_q  <= mcause_int_d;
      mcause_code_q <= mcause_code_d;
      mtval_q       <= mtval_d;
    end
  end

`ifdef KRONOS_CSR_COUNTERS_EN
  // A CSR write on the same edge replaces the increment.
  always_comb begin
    mcycle_d   = mcycle_q + CNT_ONE;
    minstret_d = instret ? (minstret_q + CNT_ONE) : minstret_q;
    if (wr_en) begin
      case (req_addr)
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[COUNTER_WIDTH-1:32], new_val};
        ADDR_MCYCLEH:   mcycle_d   = {new_val[COUNTER_WIDTH-33:0], mcycle_q[31:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[COUNTER_WIDTH-1:32], new_val};
        ADDR_MINSTRETH: minstret_d = {new_val[COUNTER_WIDTH-33:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  assign req_rdy     = (state_q == IDLE);
  assign rsp_vld     = (state_q == RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mstatus_mie = mst_mie_q;
  assign mie_mask    = mie_q;
  assign mtvec_base  = {mtvec_q, 2'b00};

endmodule

// File: tb/tb_kronos_csr_responder.sv
// Bench for kronos_csr_responder: table-driven CSR model checked every cycle, plus directed literals.
// Counter checks follow KRONOS_CSR_COUNTERS_EN, matching the build of the design.
module tb_kronos_csr_responder;
  localparam logic [31:0] TB_MTVEC = 32'h0000_1203;
  localparam int unsigned CW = 64;
  localparam logic [63:0] CMASK = (CW >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342;
  localparam logic [11:0] A_MTVAL = 12'h343, A_MIP = 12'h344;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82;
  localparam logic [1:0] OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic        req_vld = 1'b0, req_wren = 1'b0, rsp_rdy = 1'b1, instret = 1'b0;
  logic        irq_sw = 1'b0, irq_timer = 1'b0, irq_ext = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_addr = 12'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_rdy, rsp_vld, rsp_err, mstatus_mie;
  logic [31:0] rsp_rdata, mtvec_base;
  logic [2:0]  mie_mask;

  int n_checks = 0;
  int n_err = 0;

  kronos_csr_responder #(.MTVEC_RESET(TB_MTVEC), .COUNTER_WIDTH(CW)) dut (
    .clk(clk), .rstz(rstz),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wren(req_wren),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .instret(instret), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .mstatus_mie(mstatus_mie), .mie_mask(mie_mask), .mtvec_base(mtvec_base)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: CSRs as a table of stored value + writable mask
  logic [31:0] m_csr   [logic [11:0]];
  logic [31:0] m_wmask [logic [11:0]];
  logic        m_busy, m_err;
  logic [31:0] m_rdata;
  logic [63:0] m_cyc, m_ret;

  function automatic logic [31:0] m_fixed(input logic [11:0] a);
    return (a == A_MSTATUS) ? 32'h0000_1800 : 32'h0;
  endfunction

  task automatic m_reset();
    m_csr.delete();
    m_wmask.delete();
    m_wmask[A_MSTATUS] = 32'h0000_0088;  m_csr[A_MSTATUS]  = 32'h0;
    m_wmask[A_MIE]     = 32'h0000_0888;  m_csr[A_MIE]      = 32'h0;
    m_wmask[A_MTVEC]   = 32'hFFFF_FFFC;  m_csr[A_MTVEC]    = TB_MTVEC & 32'hFFFF_FFFC;
    m_wmask[A_MSCRATCH]= 32'hFFFF_FFFF;  m_csr[A_MSCRATCH] = 32'h0;
    m_wmask[A_MEPC]    = 32'hFFFF_FFFC;  m_csr[A_MEPC]     = 32'h0;
    m_wmask[A_MCAUSE]  = 32'h8000_000F;  m_csr[A_MCAUSE]   = 32'h0;
    m_wmask[A_MTVAL]   = 32'hFFFF_FFFF;  m_csr[A_MTVAL]    = 32'h0;
    m_busy = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
    m_cyc = 64'h0; m_ret = 64'h0;
  endtask

  logic [31:0] mo_old, mo_new;
  logic        mo_ok, mo_cyc_wr, mo_ret_wr;

  always @(posedge clk or negedge rstz) begin
    if (!rstz) m_reset();
    else begin
      mo_cyc_wr = 1'b0;
      mo_ret_wr = 1'b0;
      if (!m_busy) begin
        if (req_vld) begin
          mo_ok = 1'b1;
          mo_old = 32'h0;
          if (m_csr.exists(req_addr)) mo_old = m_csr[req_addr] | m_fixed(req_addr);
          else if (req_addr == A_MIP)
            mo_old = (irq_sw ? 32'h8 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_ext ? 32'h800 : 32'h0);
`ifdef KRONOS_CSR_COUNTERS_EN
          else if (req_addr == A_MCYCLE)    mo_old = m_cyc[31:0];
          else if (req_addr == A_MINSTRET)  mo_old = m_ret[31:0];
          else if (req_addr == A_MCYCLEH)   mo_old = m_cyc[63:32];
          else if (req_addr == A_MINSTRETH) mo_old = m_ret[63:32];
`endif
          else mo_ok = 1'b0;
          if (req_op == 2'b00) mo_ok = 1'b0;
          case (req_op)
            OP_RW:   mo_new = req_wdata;
            OP_RS:   mo_new = mo_old | req_wdata;
            OP_RC:   mo_new = mo_old & ~req_wdata;
            default: mo_new = mo_old;
          endcase
          m_busy  = 1'b1;
          m_err   = !mo_ok;
          m_rdata = mo_ok ? mo_old : 32'h0;
          if (mo_ok && req_wren) begin
            if (m_csr.exists(req_addr)) m_csr[req_addr] = mo_new & m_wmask[req_addr];
`ifdef KRONOS_CSR_COUNTERS_EN
            if (req_addr == A_MCYCLE)    begin m_cyc = {m_cyc[63:32], mo_new} & CMASK; mo_cyc_wr = 1'b1; end
            if (req_addr == A_MCYCLEH)   begin m_cyc = {mo_new, m_cyc[31:0]} & CMASK;  mo_cyc_wr = 1'b1; end
            if (req_addr == A_MINSTRET)  begin m_ret = {m_ret[63:32], mo_new} & CMASK; mo_ret_wr = 1'b1; end
            if (req_addr == A_MINSTRETH) begin m_ret = {mo_new, m_ret[31:0]} & CMASK;  mo_ret_wr = 1'b1; end
`endif
          end
        end
      end else if (rsp_rdy) m_busy = 1'b0;
`ifdef KRONOS_CSR_COUNTERS_EN
      if (!mo_cyc_wr) m_cyc = (m_cyc + 64'd1) & CMASK;
      if (!mo_ret_wr && instret) m_ret = (m_ret + 64'd1) & CMASK;
`endif
    end
  end

  // ---------------- per-cycle compare against the model
  logic [31:0] t_ms, t_mie;
  always @(negedge clk) begin
    t_ms  = m_csr[A_MSTATUS];
    t_mie = m_csr[A_MIE];
    chk("rsp_vld", 32'(rsp_vld), 32'(m_busy));
    chk("req_rdy", 32'(req_rdy), 32'(!m_busy));
    if (m_busy) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    chk("mstatus_mie", 32'(mstatus_mie), 32'(t_ms[3]));
    chk("mie_mask", 32'(mie_mask), 32'({t_mie[11], t_mie[7], t_mie[3]}));
    chk("mtvec_base", mtvec_base, m_csr[A_MTVEC]);
  end

  // ---------------- directed stimulus (entered and left on a falling edge)
  task automatic xact(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                      input logic wr, output logic [31:0] rd, output logic er);
    int n;
    req_vld = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_wren = wr; rsp_rdy = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp_vld && n < 10) begin @(negedge clk); n++; end
    if (!rsp_vld) begin
      n_checks++; n_err++;
      $display("FAIL rsp timeout addr %h: rsp_vld=0 want 1", a);
    end
    rd = rsp_rdata;
    er = rsp_err;
    req_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_csr(input logic [11:0] a, output logic [31:0] rd, output logic er);
    xact(OP_RS, a, 32'h0, 1'b0, rd, er);
  endtask

  logic [31:0] rd, hold_rd, cnt_a;
  logic        er;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst req_rdy", 32'(req_rdy), 32'd1);
    chk("rst rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst mtvec_base", mtvec_base, 32'h0000_1200);
    chk("rst mie_mask", 32'(mie_mask), 32'd0);
    rstz = 1'b1;
    @(negedge clk);

    xact(OP_RW, A_MTVEC, 32'h8000_0103, 1'b1, rd, er);
    chk("mtvec old", rd, 32'h0000_1200);
    chk("mtvec err", 32'(er), 32'd0);
    rd_csr(A_MTVEC, rd, er);
    chk("mtvec readback", rd, 32'h8000_0100);
    chk("mtvec_base out", mtvec_base, 32'h8000_0100);

    xact(OP_RS, A_MSTATUS, 32'h8, 1'b1, rd, er);
    chk("mstatus old", rd, 32'h0000_1800);
    rd_csr(A_MSTATUS, rd, er);
    chk("mstatus set", rd, 32'h0000_1808);
    chk("mstatus_mie set", 32'(mstatus_mie), 32'd1);
    xact(OP_RC, A_MSTATUS, 32'h8, 1'b1, rd, er);
    chk("mstatus_mie clr", 32'(mstatus_mie), 32'd0);
    xact(OP_RW, A_MSTATUS, 32'hFFFF_FFFF, 1'b1, rd, er);
    rd_csr(A_MSTATUS, rd, er);
    chk("mstatus field mask", rd, 32'h0000_1888);

    xact(OP_RW, 12'h7C0, 32'hFFFF_FFFF, 1'b1, rd, er);
    chk("unmapped err", 32'(er), 32'd1);
    chk("unmapped rdata", rd, 32'h0);
    xact(OP_RW, A_MSCRATCH, 32'hDEAD_BEEF, 1'b1, rd, er);
    chk("mscratch old", rd, 32'h0);
    xact(2'b00, A_MSCRATCH, 32'h0000_1234, 1'b1, rd, er);
    chk("op00 err", 32'(er), 32'd1);
    chk("op00 rdata", rd, 32'h0);
    rd_csr(A_MSCRATCH, rd, er);
    chk("op00 no write", rd, 32'hDEAD_BEEF);

    xact(OP_RW, A_MEPC, 32'hFFFF_FFFF, 1'b1, rd, er);
    rd_csr(A_MEPC, rd, er);
    chk("mepc mask", rd, 32'hFFFF_FFFC);
    xact(OP_RW, A_MCAUSE, 32'hFFFF_FFFF, 1'b1, rd, er);
    rd_csr(A_MCAUSE, rd, er);
    chk("mcause mask", rd, 32'h8000_000F);
    xact(OP_RW, A_MIE, 32'hFFFF_FFFF, 1'b1, rd, er);
    rd_csr(A_MIE, rd, er);
    chk("mie mask", rd, 32'h0000_0888);
    chk("mie_mask out", 32'(mie_mask), 32'd7);
    xact(OP_RC, A_MIE, 32'h0000_0888, 1'b0, rd, er);
    chk("mie_mask wren0", 32'(mie_mask), 32'd7);
    xact(OP_RC, A_MIE, 32'h0000_0080, 1'b1, rd, er);
    chk("mie_mask RC", 32'(mie_mask), 32'd5);
    xact(OP_RW, A_MTVAL, 32'h1234_5678, 1'b1, rd, er);
    rd_csr(A_MTVAL, rd, er);
    chk("mtval full", rd, 32'h1234_5678);

    // backpressure: response held, second request ignored
    req_vld = 1'b1; req_op = OP_RW; req_addr = A_MSCRATCH; req_wdata = 32'hA5A5_A5A5;
    req_wren = 1'b1; rsp_rdy = 1'b0;
    @(negedge clk);
    chk("stall rsp_vld", 32'(rsp_vld), 32'd1);
    hold_rd = rsp_rdata;
    chk("stall old", hold_rd, 32'hDEAD_BEEF);
    req_wdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall hold vld", 32'(rsp_vld), 32'd1);
      chk("stall hold rdy", 32'(req_rdy), 32'd0);
      chk("stall hold rdata", rsp_rdata, hold_rd);
    end
    rsp_rdy = 1'b1; req_vld = 1'b0;
    @(negedge clk);
    rd_csr(A_MSCRATCH, rd, er);
    chk("stall 2nd req dropped", rd, 32'hA5A5_A5A5);

    irq_timer = 1'b1;
    @(negedge clk);
    rd_csr(A_MIP, rd, er);
    chk("mip timer", rd, 32'h0000_0080);
    xact(OP_RW, A_MIP, 32'h0, 1'b1, rd, er);
    chk("mip write err", 32'(er), 32'd0);
    chk("mip write old", rd, 32'h0000_0080);
    rd_csr(A_MIP, rd, er);
    chk("mip unchanged", rd, 32'h0000_0080);
    irq_sw = 1'b1; irq_ext = 1'b1;
    rd_csr(A_MIP, rd, er);
    chk("mip all", rd, 32'h0000_0888);
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;

`ifdef KRONOS_CSR_COUNTERS_EN
    xact(OP_RW, A_MCYCLE, 32'hFFFF_FFFF, 1'b1, rd, er);
    chk("mcycle wr err", 32'(er), 32'd0);
    rd_csr(A_MCYCLEH, rd, er);
    chk("mcycleh carry", rd, 32'h1);
    xact(OP_RW, A_MCYCLEH, 32'h0000_ABCD, 1'b1, rd, er);
    rd_csr(A_MCYCLEH, rd, er);
    chk("mcycleh write", rd, 32'h0000_ABCD);
    rd_csr(A_MINSTRET, cnt_a, er);
    for (int i = 0; i < 10; i++) begin
      instret = 1'b1; @(negedge clk);
      instret = 1'b0; @(negedge clk);
    end
    rd_csr(A_MINSTRET, rd, er);
    chk("minstret +10", rd - cnt_a, 32'd10);
`else
    rd_csr(A_MCYCLE, rd, er);
    chk("mcycle absent err", 32'(er), 32'd1);
    chk("mcycle absent rdata", rd, 32'h0);
    instret = 1'b1; @(negedge clk); instret = 1'b0;
    rd_csr(A_MINSTRETH, rd, er);
    chk("minstreth absent err", 32'(er), 32'd1);
    cnt_a = 32'h0;
`endif

    // reset while a response is pending
    req_vld = 1'b1; req_op = OP_RW; req_addr = A_MSCRATCH; req_wdata = 32'h77;
    req_wren = 1'b1; rsp_rdy = 1'b0;
    @(negedge clk);
    chk("pre-reset rsp_vld", 32'(rsp_vld), 32'd1);
    #2 rstz = 1'b0; req_vld = 1'b0;
    @(negedge clk);
    chk("mid-reset rsp_vld", 32'(rsp_vld), 32'd0);
    chk("mid-reset req_rdy", 32'(req_rdy), 32'd1);
    chk("mid-reset rdata", rsp_rdata, 32'h0);
    chk("mid-reset mtvec", mtvec_base, 32'h0000_1200);
    rstz = 1'b1; rsp_rdy = 1'b1;
    @(negedge clk);
    rd_csr(A_MSCRATCH, rd, er);
    chk("post-reset mscratch", rd, 32'h0);
    rd_csr(A_MSTATUS, rd, er);
    chk("post-reset mstatus", rd, 32'h0000_1800);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
